// File: rtl/jt900h_pkg.sv
// Shared definitions for the JT900H writeback stage: SR bit positions,
// the SR reset value and the writeback FSM encoding.
package jt900h_pkg;

  localparam int SR_C    = 0;
  localparam int SR_N    = 1;
  localparam int SR_V    = 2;
  localparam int SR_H    = 4;
  localparam int SR_Z    = 6;
  localparam int SR_S    = 7;
  localparam int SR_RFP  = 8;
  localparam int SR_MAX  = 11;
  localparam int SR_IFF  = 12;
  localparam int SR_SYSM = 15;

  localparam logic [15:0] SR_RST  = 16'hF800;
  // Bits 10, 5 and 3 are reserved and always read as zero
  localparam logic [15:0] SR_MASK = 16'hFBD7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WLO  = 2'd1,
    WHI  = 2'd2
  } wbk_state_e;

  function automatic logic even_par(input logic [15:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/jt900h_wbk_if.sv
// ALU-to-writeback transaction bus. A transaction transfers on a cen-high
// clock edge where in_valid and in_ready are both high; payload is sampled only then.
interface jt900h_wbk_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_rslt;
  logic        bs;
  logic        ws;
  logic [7:0]  dst;
  logic        dst_we;
  logic [5:0]  fmask;
  logic        alu_n;
  logic        alu_z;
  logic        alu_h;
  logic        alu_v;
  logic        alu_c;
  logic        n_val;
  logic        par_sel;
  logic        sr_ld;
  logic        rfp_inc;
  logic        rfp_dec;

  modport master (
    output in_valid, alu_rslt, bs, ws, dst, dst_we, fmask,
           alu_n, alu_z, alu_h, alu_v, alu_c, n_val, par_sel,
           sr_ld, rfp_inc, rfp_dec,
    input  in_ready
  );

  modport slave (
    input  in_valid, alu_rslt, bs, ws, dst, dst_we, fmask,
           alu_n, alu_z, alu_h, alu_v, alu_c, n_val, par_sel,
           sr_ld, rfp_inc, rfp_dec,
    output in_ready
  );
endinterface

// File: rtl/jt900h_wbk_sr.sv
// Status register: flag merge from the ALU, full SR load and RFP
// register-bank pointer increment/decrement.
module jt900h_wbk_sr
  import jt900h_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd,
  input  logic        sr_ld,
  input  logic [15:0] ld_val,
  input  logic [5:0]  fmask,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_h,
  input  logic        v_src,
  input  logic        alu_c,
  input  logic        n_val,
  input  logic        rfp_inc,
  input  logic        rfp_dec,
  output logic [15:0] sr
);

  logic [15:0] sr_d, sr_q;

  always_comb begin
    sr_d = sr_q;
    if (upd) begin
      if (sr_ld) begin
        sr_d = ld_val & SR_MASK;
      end else begin
        if (fmask[5]) sr_d[SR_S] = alu_n;
        if (fmask[4]) sr_d[SR_Z] = alu_z;
        if (fmask[3]) sr_d[SR_H] = alu_h;
        if (fmask[2]) sr_d[SR_V] = v_src;
        if (fmask[1]) sr_d[SR_N] = n_val;
        if (fmask[0]) sr_d[SR_C] = alu_c;
        // Simultaneous INCF and DECF cancel out
        if (rfp_inc && !rfp_dec)
          sr_d[SR_RFP+1:SR_RFP] = sr_q[SR_RFP+1:SR_RFP] + 2'd1;
        else if (rfp_dec && !rfp_inc)
          sr_d[SR_RFP+1:SR_RFP] = sr_q[SR_RFP+1:SR_RFP] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= SR_RST;
    else        sr_q <= sr_d;
  end

  assign sr = sr_q;

endmodule

// File: rtl/jt900h_wbk.sv
// JT900H writeback stage: SR update plus 1- or 2-beat register-file write.
// Optional macro JT900H_WBK_PARITY_EN lets V take the even parity of the result.
module jt900h_wbk
  import jt900h_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  jt900h_wbk_if.slave       bus,
  output logic              rf_we,
  output logic [7:0]        rf_addr,
  output logic [15:0]       rf_din,
  output logic [1:0]        rf_wmask,
  output logic [15:0]       sr,
  output logic              cin,
  output logic              hin,
  output logic              nin,
  output logic              zin,
  output wbk_state_e        state_dbg
);

  wbk_state_e  state_d, state_q;
  logic        we_d, we_q;
  logic [7:0]  addr_d, addr_q;
  logic [15:0] din_d, din_q;
  logic [1:0]  wmask_d, wmask_q;
  logic        long_d, long_q;
  logic [15:0] hi_d, hi_q;
  logic [7:0]  hi_addr_d, hi_addr_q;
  logic        accept;
  logic        v_src;

  assign bus.in_ready = (state_q == IDLE);
  assign accept       = bus.in_valid & bus.in_ready & cen;

`ifdef JT900H_WBK_PARITY_EN
  assign v_src = bus.par_sel ?
                 even_par(bus.bs ? {8'h00, bus.alu_rslt[7:0]} : bus.alu_rslt[15:0]) :
                 bus.alu_v;
`else
  logic unused_par;
  assign unused_par = bus.par_sel;
  assign v_src      = bus.alu_v;
`endif

  jt900h_wbk_sr u_sr (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd     (accept),
    .sr_ld   (bus.sr_ld),
    .ld_val  (bus.alu_rslt[15:0]),
    .fmask   (bus.fmask),
    .alu_n   (bus.alu_n),
    .alu_z   (bus.alu_z),
    .alu_h   (bus.alu_h),
    .v_src   (v_src),
    .alu_c   (bus.alu_c),
    .n_val   (bus.n_val),
    .rfp_inc (bus.rfp_inc),
    .rfp_dec (bus.rfp_dec),
    .sr      (sr)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wmask_d   = wmask_q;
    long_d    = long_q;
    hi_d      = hi_q;
    hi_addr_d = hi_addr_q;
    if (cen) begin
      case (state_q)
        IDLE: begin
          we_d = 1'b0;
          if (accept && bus.dst_we) begin
            state_d   = WLO;
            we_d      = 1'b1;
            long_d    = ~bus.bs & ~bus.ws;
            hi_d      = bus.alu_rslt[31:16];
            hi_addr_d = {bus.dst[7:2], 2'b10};
            // Low beat is prepared now so it is on the port during WLO
            if (bus.bs) begin
              addr_d  = bus.dst;
              din_d   = {bus.alu_rslt[7:0], bus.alu_rslt[7:0]};
              wmask_d = bus.dst[0] ? 2'b10 : 2'b01;
            end else if (bus.ws) begin
              addr_d  = {bus.dst[7:1], 1'b0};
              din_d   = bus.alu_rslt[15:0];
              wmask_d = 2'b11;
            end else begin
              addr_d  = {bus.dst[7:2], 2'b00};
              din_d   = bus.alu_rslt[15:0];
              wmask_d = 2'b11;
            end
          end
        end
        WLO: begin
          if (long_q) begin
            state_d = WHI;
            we_d    = 1'b1;
            addr_d  = hi_addr_q;
            din_d   = hi_q;
            wmask_d = 2'b11;
          end else begin
            state_d = IDLE;
            we_d    = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          we_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      din_q     <= 16'h0000;
      wmask_q   <= 2'b00;
      long_q    <= 1'b0;
      hi_q      <= 16'h0000;
      hi_addr_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wmask_q   <= wmask_d;
      long_q    <= long_d;
      hi_q      <= hi_d;
      hi_addr_q <= hi_addr_d;
    end
  end

  assign rf_we     = we_q & cen;
  assign rf_addr   = addr_q;
  assign rf_din    = din_q;
  assign rf_wmask  = wmask_q;
  assign cin       = sr[SR_C];
  assign hin       = sr[SR_H];
  assign nin       = sr[SR_N];
  assign zin       = sr[SR_Z];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_jt900h_wbk.sv
// Directed-vector bench for jt900h_wbk; expected values are hand-computed.
// Define JT900H_WBK_PARITY_EN to exercise the parity option.
module tb_jt900h_wbk;
  import jt900h_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        rf_we;
  logic [7:0]  rf_addr;
  logic [15:0] rf_din;
  logic [1:0]  rf_wmask;
  logic [15:0] sr;
  logic        cin, hin, nin, zin;
  wbk_state_e  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic exp_v1, exp_v2;

  jt900h_wbk_if bus();

  jt900h_wbk dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .bus       (bus),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_din    (rf_din),
    .rf_wmask  (rf_wmask),
    .sr        (sr),
    .cin       (cin),
    .hin       (hin),
    .nin       (nin),
    .zin       (zin),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.in_valid = 1'b0; bus.alu_rslt = 32'h0; bus.bs = 1'b0; bus.ws = 1'b0;
    bus.dst = 8'h00; bus.dst_we = 1'b0; bus.fmask = 6'b0;
    bus.alu_n = 1'b0; bus.alu_z = 1'b0; bus.alu_h = 1'b0; bus.alu_v = 1'b0;
    bus.alu_c = 1'b0; bus.n_val = 1'b0; bus.par_sel = 1'b0; bus.sr_ld = 1'b0;
    bus.rfp_inc = 1'b0; bus.rfp_dec = 1'b0;
  endtask

  task automatic flag_op(input logic inc, input logic dec);
    clr_in();
    bus.in_valid = 1'b1; bus.rfp_inc = inc; bus.rfp_dec = dec;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    cen   = 1'b1;
    clr_in();
    cyc(); cyc();
    chk("rst_sr",    32'(sr), 32'hF800);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_we",    32'(rf_we), 32'd0);
    chk("rst_addr",  32'(rf_addr), 32'd0);
    chk("rst_din",   32'(rf_din), 32'd0);
    chk("rst_wmask", 32'(rf_wmask), 32'd0);
    chk("rst_flags", 32'({cin, hin, nin, zin}), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rel_we", 32'(rf_we), 32'd0);
    cyc();
    chk("rel_we2", 32'(rf_we), 32'd0);

    // Byte write to an odd address, S and Z updated only
    clr_in();
    bus.in_valid = 1'b1; bus.dst = 8'h03; bus.alu_rslt = 32'h000000A5;
    bus.fmask = 6'b110000; bus.alu_n = 1'b1; bus.alu_z = 1'b0; bus.bs = 1'b1;
    bus.dst_we = 1'b1; bus.alu_h = 1'b1; bus.alu_c = 1'b1; bus.n_val = 1'b1;
    cyc();
    clr_in();
    chk("byte_ready", 32'(bus.in_ready), 32'd0);
    chk("byte_we",    32'(rf_we), 32'd1);
    chk("byte_addr",  32'(rf_addr), 32'h03);
    chk("byte_din",   32'(rf_din), 32'hA5A5);
    chk("byte_wmask", 32'(rf_wmask), 32'b10);
    chk("byte_sr",    32'(sr), 32'hF880);
    chk("byte_nchc",  32'({nin, hin, cin}), 32'd0);
    cyc();
    chk("byte_ready2", 32'(bus.in_ready), 32'd1);
    chk("byte_we2",    32'(rf_we), 32'd0);
    chk("byte_hold",   32'(rf_din), 32'hA5A5);

    // Word write to an odd address is aligned down, C set
    bus.in_valid = 1'b1; bus.dst = 8'h21; bus.alu_rslt = 32'h0000BEEF;
    bus.ws = 1'b1; bus.dst_we = 1'b1; bus.fmask = 6'b000001; bus.alu_c = 1'b1;
    cyc();
    clr_in();
    chk("word_addr",  32'(rf_addr), 32'h20);
    chk("word_din",   32'(rf_din), 32'hBEEF);
    chk("word_wmask", 32'(rf_wmask), 32'b11);
    chk("word_sr",    32'(sr), 32'hF881);
    chk("word_cin",   32'(cin), 32'd1);
    cyc();

    // Long write: two beats, in_ready low for two cycles
    bus.in_valid = 1'b1; bus.dst = 8'h10; bus.alu_rslt = 32'h12345678; bus.dst_we = 1'b1;
    cyc();
    bus.alu_rslt = 32'hDEADDEAD; bus.dst = 8'hFF;
    bus.in_valid = 1'b0;
    chk("long_lo_state", 32'(state_dbg), 32'(WLO));
    chk("long_lo_ready", 32'(bus.in_ready), 32'd0);
    chk("long_lo", 32'({rf_we, rf_addr, rf_din, rf_wmask}), 32'({1'b1, 8'h10, 16'h5678, 2'b11}));
    cyc();
    chk("long_hi_ready", 32'(bus.in_ready), 32'd0);
    chk("long_hi", 32'({rf_we, rf_addr, rf_din, rf_wmask}), 32'({1'b1, 8'h12, 16'h1234, 2'b11}));
    cyc();
    chk("long_end_ready", 32'(bus.in_ready), 32'd1);
    chk("long_end_we",    32'(rf_we), 32'd0);
    chk("long_sr",        32'(sr), 32'hF881);
    clr_in();

    // Reset during WHI drops the second beat
    bus.in_valid = 1'b1; bus.dst = 8'h10; bus.alu_rslt = 32'h12345678; bus.dst_we = 1'b1;
    cyc();
    clr_in();
    cyc();
    chk("rwhi_state", 32'(state_dbg), 32'(WHI));
    rst_n = 1'b0;
    #1;
    chk("rwhi_rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rwhi_rst_we",    32'(rf_we), 32'd0);
    chk("rwhi_rst_sr",    32'(sr), 32'hF800);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rwhi_after_we",    32'(rf_we), 32'd0);
    chk("rwhi_after_ready", 32'(bus.in_ready), 32'd1);

    // RFP arithmetic with back-to-back flag-only transactions
    flag_op(1'b0, 1'b1);
    chk("rfp_dec_wrap", 32'(sr), 32'hFB00);
    chk("rfp_ready",    32'(bus.in_ready), 32'd1);
    flag_op(1'b1, 1'b0);
    chk("rfp_inc_wrap", 32'(sr), 32'hF800);
    chk("rfp_no_we",    32'(rf_we), 32'd0);
    flag_op(1'b0, 1'b1);
    flag_op(1'b1, 1'b1);
    chk("rfp_both",     32'(sr), 32'hFB00);
    clr_in();
    bus.in_valid = 1'b1; bus.sr_ld = 1'b1; bus.alu_rslt = 32'h0000FFFF;
    bus.fmask = 6'h3F; bus.rfp_inc = 1'b1;
    cyc();
    chk("sr_ld", 32'(sr), 32'hFBD7);
    clr_in();
    bus.in_valid = 1'b1; bus.fmask = 6'h3F;
    cyc();
    chk("flags_clr", 32'(sr), 32'hFB00);
    bus.fmask = 6'b000010; bus.n_val = 1'b1;
    cyc();
    chk("n_val_sr",  32'(sr), 32'hFB02);
    chk("n_val_nin", 32'(nin), 32'd1);
    clr_in();

    // cen low in IDLE: no accept, no SR change
    cen = 1'b0;
    bus.in_valid = 1'b1; bus.sr_ld = 1'b1; bus.alu_rslt = 32'h00000000;
    cyc();
    chk("cen0_sr",    32'(sr), 32'hFB02);
    chk("cen0_state", 32'(state_dbg), 32'(IDLE));
    clr_in();

    // Long accept with cen toggling 1,0,1,0,1
    cen = 1'b1;
    bus.in_valid = 1'b1; bus.dst = 8'h47; bus.alu_rslt = 32'hCAFEF00D; bus.dst_we = 1'b1;
    cyc();
    clr_in();
    cen = 1'b0;
    #1;
    chk("cg_lo_we0",  32'(rf_we), 32'd0);
    chk("cg_lo_data", 32'({rf_addr, rf_din}), 32'({8'h44, 16'hF00D}));
    cyc();
    chk("cg_lo_hold", 32'({state_dbg, rf_addr, rf_din}), 32'({WLO, 8'h44, 16'hF00D}));
    cen = 1'b1;
    #1;
    chk("cg_lo_we1",  32'(rf_we), 32'd1);
    cyc();
    cen = 1'b0;
    #1;
    chk("cg_hi_we0",  32'(rf_we), 32'd0);
    chk("cg_hi_data", 32'({rf_addr, rf_din}), 32'({8'h46, 16'hCAFE}));
    cyc();
    chk("cg_hi_hold", 32'({state_dbg, rf_addr, rf_din}), 32'({WHI, 8'h46, 16'hCAFE}));
    cen = 1'b1;
    #1;
    chk("cg_hi_we1",  32'(rf_we), 32'd1);
    cyc();
    chk("cg_end", 32'({bus.in_ready, rf_we}), 32'b10);

    // Parity option, alu_v chosen opposite to the parity result
`ifdef JT900H_WBK_PARITY_EN
    exp_v1 = 1'b1; exp_v2 = 1'b0;
`else
    exp_v1 = 1'b0; exp_v2 = 1'b1;
`endif
    bus.in_valid = 1'b1; bus.bs = 1'b1; bus.par_sel = 1'b1; bus.fmask = 6'b000100;
    bus.alu_rslt = 32'h00000003; bus.alu_v = 1'b0;
    cyc();
    chk("par_03", 32'(sr[SR_V]), 32'(exp_v1));
    bus.alu_rslt = 32'h00000007; bus.alu_v = 1'b1;
    cyc();
    chk("par_07", 32'(sr[SR_V]), 32'(exp_v2));
    clr_in();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jt900h_wbk.md
# jt900h_wbk

Writeback and status-register stage of the JT900H core, sitting directly after the ALU. It accepts one ALU result per transaction, updates the status register (SR) flags, and writes the result into the 16-bit register-file write port. 32-bit results take two beats. It also returns the current flags to the ALU as its carry/half/negative/zero inputs, closing the flag loop.

## Interface
- SR_RST, 16'hF800: SR value at reset (SYSM=1, IFF=7, MAX=1, RFP=0, flags clear).
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  core clock
- cen  in  1  clock enable; no state changes when low
- in_valid  in  1  transaction offered
- in_ready  out  1  stage can accept (state IDLE)
- alu_rslt  in  32  ALU result
- bs, ws  in  1 each  byte / word width (neither = long)
- dst  in  8  register-file byte address of destination
- dst_we  in  1  write result to register file
- fmask  in  6  flag update enables {S,Z,H,V,N,C}
- alu_n, alu_z, alu_h, alu_v, alu_c  in  1 each  ALU flag outputs, already width-selected
- n_val  in  1  value for N when fmask[1]
- par_sel  in  1  V takes parity of result (logic ops)
- sr_ld  in  1  load SR from alu_rslt[15:0]
- rfp_inc, rfp_dec  in  1 each  INCF / DECF
- rf_we  out  1  register-file write strobe
- rf_addr  out  8  write byte address
- rf_din  out  16  write data
- rf_wmask  out  2  byte lanes {hi,lo}
- sr  out  16  status register
- cin, hin, nin, zin  out  1 each  SR C, H, N, Z to the ALU

## Operation
- SR layout: [15] SYSM, [14:12] IFF, [11] MAX, [9:8] RFP, [7] S, [6] Z, [4] H, [2] V, [1] N, [0] C. Bits 10, 5 and 3 read 0.
- Accept = in_valid & in_ready & cen.
- On accept, SR is updated in the same edge:
  - sr_ld has priority and loads alu_rslt[15:0], with reserved bits forced to 0. fmask and rfp_inc/dec are ignored.
  - Otherwise each flag whose fmask bit is set takes its source: S=alu_n, Z=alu_z, H=alu_h, V=alu_v, N=n_val, C=alu_c.
  - RFP: rfp_inc adds 1, rfp_dec subtracts 1, both modulo 4 (3→0, 0→3). If both are set, RFP is unchanged.
- FSM states: IDLE, WLO, WHI.
  - IDLE → WLO on accept with dst_we=1. An accept with dst_we=0 stays in IDLE.
  - WLO → WHI if the latched width is long, else → IDLE.
  - WHI → IDLE.
  - Transitions occur only when cen is high.
- Write data per width:
  - Byte: rf_din = {rslt[7:0], rslt[7:0]}; rf_wmask = dst[0] ? 2'b10 : 2'b01.
  - Word: rf_din = rslt[15:0]; rf_wmask = 2'b11; dst[0] is treated as 0.
  - Long: in WLO, rslt[15:0] goes to {dst[7:2],2'b00}; in WHI, rslt[31:16] goes to {dst[7:2],2'b10}. Both beats use wmask 2'b11.
- The result, width and dst are latched on accept. Inputs may change afterwards without effect.

## Timing
- Reset values: SR=SR_RST; cin=hin=nin=zin=0; state IDLE; in_ready=1; rf_we=0; rf_addr=0; rf_din=0; rf_wmask=0.
- Accept at edge T:
  - New SR is visible after T.
  - rf_we is high for the cen cycle after T (WLO). For long results it is also high for the following cen cycle (WHI).
  - in_ready returns high after the WLO edge (byte/word) or the WHI edge (long).
- Throughput: one byte/word write every 2 cen cycles; one long write every 3; flag-only transactions every cycle.
- rf_we is low whenever cen is low. Outputs hold their values while cen is low.
- Reset during WLO/WHI: the FSM returns to IDLE immediately and the remaining beats are dropped.

## Configuration
- JT900H_WBK_PARITY_EN defined: when par_sel=1 and fmask[2]=1, V = even parity of the latched result. The result is rslt[7:0] for byte and rslt[15:0] for word/long; V=1 when the number of ones is even.
- Not defined: par_sel is ignored and V always takes alu_v.

## Structure
- Shared package jt900h_pkg holds the SR bit-position localparams (SR_C…SR_SYSM), the SR_RST default, and the state encoding (IDLE=2'd0, WLO=2'd1, WHI=2'd2).
- One sub-module, jt900h_wbk_sr, holds the SR register, the flag-merge logic and RFP arithmetic. The FSM and write-port logic stay in the top module.

## Test plan
- Reset then idle: sr=F800h, in_ready=1, rf_we=0; release rst_n mid-cycle → no spurious write.
- Byte write: dst=8'h03, rslt=32'h000000A5, fmask=6'b110000, alu_n=1, alu_z=0, bs=1 → one beat: rf_addr=03h, rf_din=A5A5h, wmask=10; S=1, Z=0, other flags unchanged; in_ready low for exactly 1 cycle.
- Long write: rslt=12345678h, dst=8'h10 → beats (10h,5678h,11) then (12h,1234h,11); in_ready low for 2 cycles. Assert rst_n low during WHI → second beat absent, state IDLE.
- RFP wrap: rfp_dec with RFP=0 → 3; rfp_inc at 3 → 0; both set → unchanged; sr_ld with alu_rslt=FFFFh plus fmask=3Fh → sr=FBD7h.
- cen gating: a long accept with cen toggling 1,0,1,0,1 → beats only on cen-high edges, rf_we=0 when cen=0, data held.
- Parity (macro on): byte rslt=03h, par_sel=1, fmask[2]=1 → V=1; rslt=07h → V=0. With the macro off, V follows alu_v.
